// File: rtl/counter_pkg.sv
// Shared types and constants for the counter event front end.
// Latency: none, declarations only.
// Backpressure: not applicable.
// Build option: COUNTER_EVENTS_FILTER_EN enables the per-pin glitch filter.
package counter_pkg;

    // Edge selection encoding shared by every probe pin.
    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_t;

    // Cycles the synchroniser and history flop need to hold real pin data
    // after reset release; the glitch filter adds FILTER_LEN on top.
    localparam int ARM_BASE_LEN = 3;

`ifdef COUNTER_EVENTS_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    // True when the transition prev -> cur matches the selected edge type.
    function automatic logic edge_match(input edge_sel_t sel, input logic prev, input logic cur);
        logic m;
        m = 1'b0;
        case (sel)
            EDGE_OFF:  m = 1'b0;
            EDGE_RISE: m = cur & ~prev;
            EDGE_FALL: m = ~cur & prev;
            EDGE_BOTH: m = cur ^ prev;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// One probe pin: two-flop synchroniser, optional glitch filter, history flop, edge compare.
// Latency: hit is combinational from the history stage, 2 cycles after the pin is sampled (+FILTER_LEN filtered).
// Backpressure: none; hit is a one-cycle pulse that the parent must register every cycle.
// Build option: COUNTER_EVENTS_FILTER_EN inserts the stability filter.
module edge_sync
    import counter_pkg::*;
`ifdef COUNTER_EVENTS_FILTER_EN
#(
    parameter int FILTER_LEN = 4
)
`endif
(
    input  logic      clk,
    input  logic      sysrst,
    input  logic      pin,
    input  edge_sel_t edge_sel,
    output logic      hit
);

    logic sync1;
    logic sync2;
    logic level;
    logic hist;

    // Two-flop synchroniser for the asynchronous probe input.
    always_ff @(posedge clk) begin
        if (sysrst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef COUNTER_EVENTS_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] stab_cnt;
    logic          filt;

    // Filtered level follows the synchronised pin only after FILTER_LEN
    // consecutive samples that disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (sysrst) begin
            stab_cnt <= '0;
            filt     <= 1'b0;
        end else if (sync2 == filt) begin
            stab_cnt <= '0;
        end else if (stab_cnt == CW'(FILTER_LEN - 1)) begin
            stab_cnt <= '0;
            filt     <= sync2;
        end else begin
            stab_cnt <= stab_cnt + CW'(1);
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    // History flop holds the previous level for edge comparison.
    always_ff @(posedge clk) begin
        if (sysrst) begin
            hist <= 1'b0;
        end else begin
            hist <= level;
        end
    end

    assign hit = edge_match(edge_sel, hist, level);

endmodule

// File: rtl/counter_events.sv
// Event front end: turns probe pins and host requests into single-cycle counter strobes.
// Latency: pins 3 cycles (+FILTER_LEN with filter), clr/ld 1 cycle.
// Backpressure: none; the counter must accept a strobe on every cycle it is asserted.
// Build option: COUNTER_EVENTS_FILTER_EN adds a glitch filter to every pin.
module counter_events
    import counter_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 8,
    parameter int FILTER_LEN     = 4
)
(
    input  logic                      clk,
    input  logic                      sysrst,
    input  logic                      start_pin,
    input  logic                      stop_pin,
    input  logic                      count_pin,
    input  logic [1:0]                start_edge,
    input  logic [1:0]                stop_edge,
    input  logic [1:0]                count_edge,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      clr,
    input  logic                      ld,
    output logic                      start,
    output logic                      stop,
    output logic                      count,
    output logic                      reset,
    output logic                      load
);

    localparam int ARM_LEN = ARM_BASE_LEN + (FILTER_EN ? FILTER_LEN : 0);
    localparam int AW      = $clog2(ARM_LEN + 1);

    logic [AW-1:0]             arm_cnt;
    logic                      armed;
    logic                      start_hit;
    logic                      stop_hit;
    logic                      count_hit;
    logic                      count_qual;
    logic [PRESCALE_WIDTH-1:0] pcnt;

`ifdef COUNTER_EVENTS_FILTER_EN
    edge_sync #(.FILTER_LEN(FILTER_LEN)) u_start (
        .clk(clk), .sysrst(sysrst), .pin(start_pin), .edge_sel(edge_sel_t'(start_edge)), .hit(start_hit)
    );
    edge_sync #(.FILTER_LEN(FILTER_LEN)) u_stop (
        .clk(clk), .sysrst(sysrst), .pin(stop_pin), .edge_sel(edge_sel_t'(stop_edge)), .hit(stop_hit)
    );
    edge_sync #(.FILTER_LEN(FILTER_LEN)) u_count (
        .clk(clk), .sysrst(sysrst), .pin(count_pin), .edge_sel(edge_sel_t'(count_edge)), .hit(count_hit)
    );
`else
    edge_sync u_start (
        .clk(clk), .sysrst(sysrst), .pin(start_pin), .edge_sel(edge_sel_t'(start_edge)), .hit(start_hit)
    );
    edge_sync u_stop (
        .clk(clk), .sysrst(sysrst), .pin(stop_pin), .edge_sel(edge_sel_t'(stop_edge)), .hit(stop_hit)
    );
    edge_sync u_count (
        .clk(clk), .sysrst(sysrst), .pin(count_pin), .edge_sel(edge_sel_t'(count_edge)), .hit(count_hit)
    );
`endif

    // Arm counter: edges are ignored until the pipeline holds only post-reset
    // samples, so a pin already high at release cannot fake an edge.
    always_ff @(posedge clk) begin
        if (sysrst) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + AW'(1);
        end
    end

    assign armed      = (arm_cnt == AW'(ARM_LEN));
    assign count_qual = count_hit & armed;

    // Start/stop and host request strobes: one registered pulse per qualifying cycle.
    always_ff @(posedge clk) begin
        if (sysrst) begin
            start <= 1'b0;
            stop  <= 1'b0;
            reset <= 1'b0;
            load  <= 1'b0;
        end else begin
            start <= start_hit & armed;
            stop  <= stop_hit & armed;
            reset <= clr;
            load  <= ld;
        end
    end

    // Count prescaler: clr wins over a coincident edge; >= keeps a lowered
    // divisor from letting pcnt run past it and wrap.
    always_ff @(posedge clk) begin
        if (sysrst) begin
            pcnt  <= '0;
            count <= 1'b0;
        end else begin
            count <= 1'b0;
            if (clr) begin
                pcnt <= '0;
            end else if (count_qual) begin
                if (pcnt >= prescale) begin
                    pcnt  <= '0;
                    count <= 1'b1;
                end else begin
                    pcnt <= pcnt + PRESCALE_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_events.sv
// Directed self-checking bench for counter_events.
// Stimulus is applied 1 time unit after each rising edge and outputs are sampled there too.
// Build option: COUNTER_EVENTS_FILTER_EN also runs the glitch filter scenario.
module tb_counter_events;

    localparam int PW = 8;
    localparam int FL = 4;
`ifdef COUNTER_EVENTS_FILTER_EN
    localparam int LAT = 3 + FL;
    localparam int G   = 2 * FL;
`else
    localparam int LAT = 3;
    localparam int G   = 2;
`endif

    logic          clk = 1'b0;
    logic          sysrst;
    logic          start_pin, stop_pin, count_pin;
    logic [1:0]    start_edge, stop_edge, count_edge;
    logic [PW-1:0] prescale;
    logic          clr, ld;
    logic          start, stop, count, reset, load;

    int n_cmp  = 0;
    int n_fail = 0;

    // Stimulus masks: bit s set means act just before edge s+1.
    logic [127:0] st_start, st_stop, st_count, st_clr, st_ld;
    // Observed masks: bit s set means the strobe was high after edge s.
    logic [127:0] ob_start, ob_stop, ob_count, ob_reset, ob_load;
    logic [127:0] e_start, e_stop, e_count, e_reset, e_load;

    counter_events #(.PRESCALE_WIDTH(PW), .FILTER_LEN(FL)) dut (
        .clk(clk), .sysrst(sysrst),
        .start_pin(start_pin), .stop_pin(stop_pin), .count_pin(count_pin),
        .start_edge(start_edge), .stop_edge(stop_edge), .count_edge(count_edge),
        .prescale(prescale), .clr(clr), .ld(ld),
        .start(start), .stop(stop), .count(count), .reset(reset), .load(load)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] b(input int i);
        logic [127:0] one;
        one = 128'd1;
        return one << i;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_case();
        st_start = '0; st_stop = '0; st_count = '0; st_clr = '0; st_ld = '0;
        e_start  = '0; e_stop  = '0; e_count  = '0; e_reset = '0; e_load = '0;
    endtask

    task automatic run(input int n);
        ob_start = '0; ob_stop = '0; ob_count = '0; ob_reset = '0; ob_load = '0;
        for (int s = 0; s < n; s++) begin
            if (st_start[s]) start_pin = ~start_pin;
            if (st_stop[s])  stop_pin  = ~stop_pin;
            if (st_count[s]) count_pin = ~count_pin;
            clr = st_clr[s];
            ld  = st_ld[s];
            step();
            ob_start[s+1] = start;
            ob_stop[s+1]  = stop;
            ob_count[s+1] = count;
            ob_reset[s+1] = reset;
            ob_load[s+1]  = load;
        end
        clr = 1'b0;
        ld  = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        sysrst = 1'b1;
        start_pin = 1'b0; stop_pin = 1'b0; count_pin = 1'b0;
        start_edge = 2'b00; stop_edge = 2'b00; count_edge = 2'b00;
        prescale = '0;
        clr = 1'b1; ld = 1'b1;
        repeat (3) step();
        outs = {start, stop, count, reset, load};
        n_cmp++;
        if (outs !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs got %b want 00000", outs);
        end
        clr = 1'b0; ld = 1'b0;
        sysrst = 1'b0;
        new_case();
        run(LAT + G + 4);
        n_cmp++;
        if ((ob_start | ob_stop | ob_count | ob_reset | ob_load) !== '0) begin
            n_fail++; $display("FAIL arm_idle got %h want 0", ob_start | ob_stop | ob_count | ob_reset | ob_load);
        end
    endtask

    task automatic test_start_stop();
        start_edge = 2'b01; stop_edge = 2'b10; count_edge = 2'b00;
        new_case();
        st_start = b(0) | b(2*G);
        st_stop  = b(0) | b(2*G);
        e_start  = b(LAT);
        e_stop   = b(2*G + LAT);
        run(4*G + LAT);
        n_cmp++;
        if (ob_start !== e_start) begin
            n_fail++; $display("FAIL start_rise_only got %h want %h", ob_start, e_start);
        end
        n_cmp++;
        if (ob_stop !== e_stop) begin
            n_fail++; $display("FAIL stop_fall_only got %h want %h", ob_stop, e_stop);
        end
        // Both edges selected, start and stop together; count pin toggles but is disabled.
        start_edge = 2'b11; stop_edge = 2'b11;
        new_case();
        st_start = b(0) | b(G);
        st_stop  = b(0) | b(G);
        st_count = b(0) | b(G);
        e_start  = b(LAT) | b(G + LAT);
        e_stop   = b(LAT) | b(G + LAT);
        run(2*G + LAT);
        n_cmp++;
        if ({ob_start, ob_stop} !== {e_start, e_stop}) begin
            n_fail++; $display("FAIL start_stop_same_cycle got %h %h want %h %h", ob_start, ob_stop, e_start, e_stop);
        end
        n_cmp++;
        if (ob_count !== '0) begin
            n_fail++; $display("FAIL count_edge_off got %h want 0", ob_count);
        end
        start_edge = 2'b00; stop_edge = 2'b00;
    endtask

    task automatic test_prescale();
        count_edge = 2'b11;
        prescale = 8'd2;
        new_case();
        for (int i = 0; i < 9; i++) st_count |= b(i*G);
        e_count = b(2*G + LAT) | b(5*G + LAT) | b(8*G + LAT);
        run(8*G + LAT + 3);
        n_cmp++;
        if (ob_count !== e_count) begin
            n_fail++; $display("FAIL prescale_div3 got %h want %h", ob_count, e_count);
        end
    endtask

    task automatic test_prescale_change();
        count_edge = 2'b11;
        prescale = 8'd5;
        new_case();
        for (int i = 0; i < 4; i++) st_count |= b(i*G);
        run(4*G + LAT);
        n_cmp++;
        if (ob_count !== '0) begin
            n_fail++; $display("FAIL prescale5_fill got %h want 0", ob_count);
        end
        // pcnt is now 4; lowering the divisor to 1 must fire on the next edge.
        prescale = 8'd1;
        new_case();
        st_count = b(0) | b(G) | b(2*G);
        e_count  = b(LAT) | b(2*G + LAT);
        run(2*G + LAT + 3);
        n_cmp++;
        if (ob_count !== e_count) begin
            n_fail++; $display("FAIL prescale_lowered got %h want %h", ob_count, e_count);
        end
    endtask

    task automatic test_clr_ld();
        int t1, c2, c3, c4;
        count_edge = 2'b11;
        prescale = 8'd0;
        t1 = 2*G;
        c2 = t1 + LAT + 2;
        c3 = c2 + 5;
        c4 = c3 + 2;
        new_case();
        st_count = b(0) | b(t1);
        st_clr   = b(LAT - 1) | b(c2) | b(c2 + 1) | b(c2 + 2) | b(c4);
        st_ld    = b(c3) | b(c4);
        e_count  = b(t1 + LAT);
        e_reset  = b(LAT) | b(c2 + 1) | b(c2 + 2) | b(c2 + 3) | b(c4 + 1);
        e_load   = b(c3 + 1) | b(c4 + 1);
        run(c4 + 4);
        n_cmp++;
        if (ob_count !== e_count) begin
            n_fail++; $display("FAIL clr_discards_edge got %h want %h", ob_count, e_count);
        end
        n_cmp++;
        if (ob_reset !== e_reset) begin
            n_fail++; $display("FAIL reset_strobes got %h want %h", ob_reset, e_reset);
        end
        n_cmp++;
        if (ob_load !== e_load) begin
            n_fail++; $display("FAIL load_strobes got %h want %h", ob_load, e_load);
        end
        // ld leaves pcnt alone; clr zeroes it.
        prescale = 8'd1;
        new_case();
        st_count = b(0) | b(2*G) | b(4*G) | b(6*G) | b(8*G);
        st_ld    = b(LAT + 1);
        st_clr   = b(4*G + LAT + 1);
        e_count  = b(2*G + LAT) | b(8*G + LAT);
        e_reset  = b(4*G + LAT + 2);
        e_load   = b(LAT + 2);
        run(8*G + LAT + 3);
        n_cmp++;
        if (ob_count !== e_count) begin
            n_fail++; $display("FAIL pcnt_ld_clr got %h want %h", ob_count, e_count);
        end
        n_cmp++;
        if ({ob_reset, ob_load} !== {e_reset, e_load}) begin
            n_fail++; $display("FAIL ld_clr_strobes got %h %h want %h %h", ob_reset, ob_load, e_reset, e_load);
        end
    endtask

    task automatic test_sysrst();
        logic [4:0] acc;
        start_edge = 2'b11; stop_edge = 2'b00; count_edge = 2'b10;
        prescale = 8'd0;
        start_pin = ~start_pin;
        step();
        // Reset lands while the start edge is still in the pipeline.
        sysrst = 1'b1;
        count_pin = 1'b1;
        acc = '0;
        repeat (4) begin
            step();
            acc |= {start, stop, count, reset, load};
        end
        n_cmp++;
        if (acc !== 5'b0) begin
            n_fail++; $display("FAIL midrun_reset got %b want 00000", acc);
        end
        sysrst = 1'b0;
        new_case();
        run(LAT + 2*G);
        n_cmp++;
        if ((ob_start | ob_count) !== '0) begin
            n_fail++; $display("FAIL held_high_release got %h %h want 0 0", ob_start, ob_count);
        end
        new_case();
        st_count = b(0);
        e_count  = b(LAT);
        run(LAT + 3);
        n_cmp++;
        if (ob_count !== e_count) begin
            n_fail++; $display("FAIL fall_after_release got %h want %h", ob_count, e_count);
        end
        start_edge = 2'b00; count_edge = 2'b00;
    endtask

`ifdef COUNTER_EVENTS_FILTER_EN
    task automatic test_filter();
        start_edge = 2'b01;
        start_pin = 1'b0;
        new_case();
        run(2*G);
        new_case();
        // 3-sample glitch, then a 5-sample pulse.
        st_start = b(0) | b(3) | b(10) | b(15);
        e_start  = b(10 + LAT);
        run(30);
        n_cmp++;
        if (ob_start !== e_start) begin
            n_fail++; $display("FAIL filter_glitch_pulse got %h want %h", ob_start, e_start);
        end
        start_edge = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_start_stop();
        test_prescale();
        test_prescale_change();
        test_clr_ld();
        test_sysrst();
`ifdef COUNTER_EVENTS_FILTER_EN
        test_filter();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
